// File: rtl/surf_trig_pkg.sv
// -----------------------------------------------------------------------------
// surf_trig_pkg
// Shared definitions for the SURF trigger word link. The transmitter and the
// receiver-side decode both import this package, so both ends agree on word
// widths, the HDR flag position, and the frame state encoding.
// -----------------------------------------------------------------------------
package surf_trig_pkg;

    localparam int TRIG_WORD_W = 16;
    localparam int TRIG_ADDR_W = 12;
    localparam int TRIG_META_W = 8;

    localparam logic [TRIG_WORD_W-1:0] TRIG_HDR_FLAG = 16'h8000;
    localparam logic [TRIG_WORD_W-1:0] TRIG_IDLE     = 16'h0000;

    // Frame state: a HDR frame is always followed by exactly one META frame.
    typedef enum logic [0:0] {
        IDLE_S = 1'b0,
        META_S = 1'b1
    } trig_state_e;

    // One queued trigger event.
    typedef struct packed {
        logic [TRIG_META_W-1:0] meta;
        logic [TRIG_ADDR_W-1:0] addr;
    } trig_evt_t;

    // HDR = {1, 000, addr}
    function automatic logic [TRIG_WORD_W-1:0] trig_hdr_word(
        input logic [TRIG_ADDR_W-1:0] addr
    );
        return TRIG_HDR_FLAG | {4'h0, addr};
    endfunction

    // META = {00, meta}
    function automatic logic [TRIG_WORD_W-1:0] trig_meta_word(
        input logic [TRIG_META_W-1:0] meta
    );
        return {8'h00, meta};
    endfunction

    // Receiver-side decode: a word carrying the HDR flag starts an event.
    function automatic logic trig_is_hdr(input logic [TRIG_WORD_W-1:0] word);
        return (word & TRIG_HDR_FLAG) != TRIG_IDLE;
    endfunction

endpackage

// File: rtl/trig_evt_fifo.sv
// -----------------------------------------------------------------------------
// trig_evt_fifo
// Synchronous FIFO with asynchronous active-high reset. Read data is the
// current head entry (show-ahead), valid whenever empty is low.
// When full, a push in the same cycle as a pop is accepted because the pop
// frees the slot first; a push while full without a pop is dropped and
// flagged on drop for one cycle.
//
// Ports:
//   clk          clock
//   rst          asynchronous reset, active high; empties the FIFO
//   push         write request
//   push_data    data written on an accepted push
//   pop          read request (ignored when empty)
//   pop_data     head entry
//   full/empty   occupancy flags
//   drop         push rejected this cycle (combinational)
//   nonempty_nxt FIFO will be non-empty after this clock edge
// -----------------------------------------------------------------------------
module trig_evt_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             drop,
    output logic             nonempty_nxt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    assign do_pop  = pop && !empty;
    // Pop-before-push: a simultaneous pop makes room even when full.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;

    assign count_nxt    = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign nonempty_nxt = (count_nxt != '0);

    assign pop_data = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; the pointers and count define
    // which entries are meaningful, and an unreset array maps to plain RAM/regs.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/surf_trig_word_tx.sv
// -----------------------------------------------------------------------------
// surf_trig_word_tx
// SURF-side trigger word transmitter. Queues single-cycle trigger events and
// serializes each as a HDR frame followed by a META frame, one 16-bit word per
// 4-cycle frame, aligned to sysclk_phase_i. Frames with nothing to send carry
// IDLE words.
//
// Ports:
//   sysclk_i          system clock (125 MHz)
//   rst_i             asynchronous reset, active high
//   sysclk_phase_i    one-cycle pulse marking a frame start
//   trig_valid_i      one-cycle trigger event strobe
//   trig_addr_i       trigger address/time, sampled with trig_valid_i
//   trig_meta_i       metadata, sampled with trig_valid_i
//   trig_dat_o        trigger word, held for a full frame
//   trig_dat_valid_o  one-cycle strobe when trig_dat_o updates
//   drop_count_o      saturating count of events lost to a full queue
//   busy_o            queue non-empty or a META word still pending
// -----------------------------------------------------------------------------
module surf_trig_word_tx
    import surf_trig_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                   sysclk_i,
    input  logic                   rst_i,
    input  logic                   sysclk_phase_i,
    input  logic                   trig_valid_i,
    input  logic [TRIG_ADDR_W-1:0] trig_addr_i,
    input  logic [TRIG_META_W-1:0] trig_meta_i,
    output logic [TRIG_WORD_W-1:0] trig_dat_o,
    output logic                   trig_dat_valid_o,
    output logic [CNT_WIDTH-1:0]   drop_count_o,
    output logic                   busy_o
);

    trig_evt_t              push_evt;
    trig_evt_t              head_evt;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_drop;
    logic                   fifo_nonempty_nxt;
    logic                   pop;
    trig_state_e            state_q;
    trig_state_e            state_d;
    logic [TRIG_META_W-1:0] meta_q;

    assign push_evt = '{meta: trig_meta_i, addr: trig_addr_i};

    // The pop decision uses the registered empty flag, so an event pushed on
    // a phase cycle is only seen at the following frame start.
    assign pop = sysclk_phase_i && (state_q == IDLE_S) && !fifo_empty;

    trig_evt_fifo #(
        .WIDTH ($bits(trig_evt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (sysclk_i),
        .rst          (rst_i),
        .push         (trig_valid_i),
        .push_data    (push_evt),
        .pop          (pop),
        .pop_data     (head_evt),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .drop         (fifo_drop),
        .nonempty_nxt (fifo_nonempty_nxt)
    );

    // NOTE: every signal driven from always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        if (sysclk_phase_i) begin
            case (state_q)
                IDLE_S:  state_d = fifo_empty ? IDLE_S : META_S;
                META_S:  state_d = IDLE_S;
                default: state_d = IDLE_S;
            endcase
        end
    end

    // Frame state, output word and the META latch.
    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q          <= IDLE_S;
            meta_q           <= '0;
            trig_dat_o       <= TRIG_IDLE;
            trig_dat_valid_o <= 1'b0;
        end else begin
            state_q          <= state_d;
            trig_dat_valid_o <= sysclk_phase_i;
            if (sysclk_phase_i) begin
                case (state_q)
                    IDLE_S: begin
                        if (!fifo_empty) begin
                            trig_dat_o <= trig_hdr_word(head_evt.addr);
                            meta_q     <= head_evt.meta;
                        end else begin
                            trig_dat_o <= TRIG_IDLE;
                        end
                    end
                    META_S:  trig_dat_o <= trig_meta_word(meta_q);
                    default: trig_dat_o <= TRIG_IDLE;
                endcase
            end
        end
    end

    // Dropped-event counter, saturating at all-ones.
    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_count_o <= '0;
        end else if (fifo_drop && (drop_count_o != '1)) begin
            drop_count_o <= drop_count_o + 1'b1;
        end
    end

    // Busy reflects the queue and state as they will be after this edge.
    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_o <= 1'b0;
        end else begin
            busy_o <= fifo_nonempty_nxt || (state_d == META_S);
        end
    end

endmodule
